datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Sequencing controller that drives the control side of the 16-bit `datapath` (register file, A/B/C registers, shifter, ALU, status).

- Accepts one 16-bit instruction per valid/ready handshake.
- Decodes it and steps the datapath's load/select/write strobes through a fixed multi-cycle schedule.
- Pulses `done` when the result has been written (or the status updated).
- Sits between the instruction source and `datapath`. Every datapath control input except `clk` is driven from here.

## Interface
Parameters:
- `DATA_W`, 16: datapath width. Only 16 is supported.
- `SEXT`, 1: 1 means imm8 is sign-extended onto `datapath_in`; 0 means zero-extended.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  16  instruction word; sampled only on handshake.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `done`  out  1  one-cycle pulse when an instruction completes.
- `err`  out  1  one-cycle pulse when an undefined encoding is rejected.
- `datapath_in`  out  16  extended imm8, for `datapath_in`.
- `vsel`  out  1  1 selects `datapath_in`; 0 selects C (`datapath_out`) as write-back data.
- `writenum`, `readnum`  out  3 each  register-file write/read index.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  A/B/C/status load enables.
- `asel`  out  1  1 forces the ALU A input to 0.
- `bsel`  out  1  0 selects the shifter output as the ALU B input.
- `shift`  out  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- `ALUop`  out  2  00 add, 01 sub, 10 and, 11 not-B.

## Operation
Fields:
- [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.

Legal encodings:
- MOV-imm: 110/10.
- MOV-reg: 110/00.
- ADD: 101/00.
- CMP: 101/01.
- AND: 101/10.
- MVN: 101/11.
- Anything else is illegal.

Latching:
- On `in_valid && in_ready` at an edge, `instr` is latched.
- The latched copy drives all decode until the next handshake.
- Changes on the `instr` port after acceptance have no effect.

States: IDLE, WIMM, GETA, GETB, EXEC, WRC, DONE, ERR.
- IDLE:
  - `in_ready` is 1.
  - An accepted legal MOV-imm goes to WIMM.
  - ADD, CMP, AND go to GETA.
  - MOV-reg and MVN go to GETB.
  - An illegal encoding goes to ERR.
- WIMM:
  - Drives `vsel`=1, `writenum`=Rn, `write`=1, and `datapath_in` = extended imm8.
  - Next state DONE.
- GETA:
  - Drives `readnum`=Rn, `loada`=1.
  - Next state GETB.
- GETB:
  - Drives `readnum`=Rm, `loadb`=1.
  - Next state EXEC.
- EXEC:
  - Drives `shift`=sh, `bsel`=0, and `ALUop` = op.
  - MOV-reg uses `ALUop`=00.
  - `asel`=1 for MOV-reg and MVN; otherwise 0.
  - `loadc`=1 for every opcode except CMP.
  - `loads`=1 for ADD, CMP, AND, MVN only.
  - Next state is DONE for CMP, otherwise WRC.
- WRC:
  - Drives `vsel`=0, `writenum`=Rd, `write`=1.
  - Next state DONE.
- DONE:
  - `done`=1.
  - Next state IDLE.
- ERR:
  - `err`=1. No strobe is asserted.
  - Next state IDLE.

Output rules:
- Outputs are Moore functions of state plus the latched instruction.
- In every state, any strobe not listed above is 0.
- Any select or index not listed above holds 0.

## Timing
Reset:
- Takes effect at the first rising edge with `reset`=1, in any state including mid-instruction. The next cycle is IDLE.
- The latched instruction is cleared to 0.
- The following outputs are 0 from that edge onward: `write`, `loada`, `loadb`, `loadc`, `loads`, `done`, `err`, `vsel`, `asel`, `bsel`, `shift`, `ALUop`, `writenum`, `readnum`, `datapath_in`.
- `in_ready` is 1.

Latency, counted from the accepting edge to the cycle where `done` is high:
- MOV-imm: 2.
- MOV-reg and MVN: 4.
- CMP: 4.
- ADD and AND: 5.
- Illegal encoding: `err` is high in cycle 1 and `done` never rises.

Handshake:
- No new instruction is accepted until IDLE.
- Back-to-back throughput is therefore latency + 1 cycles.
- `in_valid` held high across DONE is accepted on the edge after DONE.

Timing guarantees:
- Each strobe is high for exactly one cycle per instruction.
- Every load captures at the edge that ends its state.
- Write-back in WRC therefore sees C as loaded by EXEC.

## Structure
- `datapath_ctrl_pkg` contains:
  - the state enum;
  - opcode/op constants;
  - `ALUop` codes;
  - `shift` codes;
  - field bit positions.
- Sub-module `datapath_ctrl_dec`: combinational field extraction, legality check, and imm8 extension.
- Top level: state register, instruction latch, output decode.

## Test plan
Each scenario is run with `datapath` attached:
1. Reset: hold `reset` for 2 cycles.
   - Required: all strobes 0, `in_ready`=1, `done`=0.
2. Load and add: accept 16'hD102 (MOV R1,#2), then 16'hD007 (MOV R0,#7), then 16'hA148 (ADD R2,R1,R0,LSL#1).
   - Required: `done` at acceptance+2, +2, and +5 respectively.
   - Required: `datapath_out`=16'h0010; `Z_out`=0.
3. Compare: accept 16'hA901 (CMP R1,R1).
   - Required: `loads` pulses in EXEC, `write` is never asserted, `Z_out`=1, `done` at +4.
4. Complement: accept 16'hB860 (MVN R3,R0).
   - Required: `asel`=1 and `ALUop`=11 in EXEC; R3 = 16'hFFF8; `done` at +4.
5. Illegal encoding: accept 16'hE000.
   - Required: `err` pulses one cycle after acceptance, no strobe is asserted, `in_ready` returns the next cycle.
6. Reset mid-operation: assert `reset` while in EXEC of an ADD.
   - Required: next cycle IDLE, `write`=0, destination register unchanged, `done` never pulses.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Purpose: shared types and constants for the datapath sequencing controller.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package datapath_ctrl_pkg;

  localparam int DATA_W_C = 16;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcode / op constants
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  // ALUop codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // shift codes
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WIMM, ST_GETA, ST_GETB, ST_EXEC, ST_WRC, ST_DONE, ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_ILL
  } kind_e;

  // Fully decoded view of one instruction word
  typedef struct packed {
    kind_e                 kind;
    logic [2:0]            rn;
    logic [2:0]            rd;
    logic [2:0]            rm;
    logic [1:0]            op;
    logic [1:0]            sh;
    logic [DATA_W_C-1:0]   imm;
  } dec_t;

  // Legality / instruction class from opcode and op fields
  function automatic kind_e classify(input logic [2:0] opc, input logic [1:0] op);
    kind_e k;
    k = K_ILL;
    if (opc == OPC_MOV) begin
      if (op == OP_MOVI)      k = K_MOVI;
      else if (op == OP_MOVR) k = K_MOVR;
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  k = K_ADD;
        OP_CMP:  k = K_CMP;
        OP_AND:  k = K_AND;
        default: k = K_MVN;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/datapath_ctrl_dec.sv
// Purpose: field extraction, legality check and imm8 extension of one instruction.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: instr (16-bit word in) -> dec (packed decode struct out).
module datapath_ctrl_dec
  import datapath_ctrl_pkg::*;
#(
  parameter bit SEXT = 1'b1
) (
  input  logic [DATA_W_C-1:0] instr,
  output dec_t                dec
);

  logic [7:0] imm8;

  always_comb begin
    imm8     = instr[IMM_HI:IMM_LO];
    dec      = '0;
    dec.kind = classify(instr[OPC_HI:OPC_LO], instr[OP_HI:OP_LO]);
    dec.rn   = instr[RN_HI:RN_LO];
    dec.rd   = instr[RD_HI:RD_LO];
    dec.rm   = instr[RM_HI:RM_LO];
    dec.op   = instr[OP_HI:OP_LO];
    dec.sh   = instr[SH_HI:SH_LO];
    if (SEXT) dec.imm = {{(DATA_W_C-8){imm8[7]}}, imm8};
    else      dec.imm = {{(DATA_W_C-8){1'b0}}, imm8};
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Purpose: sequences datapath load/select/write strobes for one instruction at a time.
// Latency: accept->done MOV-imm 2, MOV-reg/MVN/CMP 4, ADD/AND 5; illegal -> err at 1.
// Backpressure: in_ready high only in IDLE; instr port ignored until the next handshake.
// Ports: clk/reset; instr/in_valid/in_ready handshake; done/err pulses;
//        datapath controls datapath_in, vsel, writenum, readnum, write,
//        loada/b/c, loads, asel, bsel, shift, ALUop.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit SEXT   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] datapath_in,
  output logic              vsel,
  output logic [2:0]        writenum,
  output logic [2:0]        readnum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              accept;
  kind_e             in_kind;
  dec_t              dec_q;

  // All outputs decode from the latched copy only
  datapath_ctrl_dec #(.SEXT(SEXT)) u_dec (
    .instr (instr_q),
    .dec   (dec_q)
  );

  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    accept  = in_valid && (state_q == ST_IDLE);
    instr_d = accept ? instr : instr_q;
    // Dispatch needs the class of the word being accepted, before it is latched
    in_kind = classify(instr[OPC_HI:OPC_LO], instr[OP_HI:OP_LO]);
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_kind)
            K_MOVI:              state_d = ST_WIMM;
            K_ADD, K_CMP, K_AND: state_d = ST_GETA;
            K_MOVR, K_MVN:       state_d = ST_GETB;
            default:             state_d = ST_ERR;
          endcase
        end
      end
      ST_WIMM: state_d = ST_DONE;
      ST_GETA: state_d = ST_GETB;
      ST_GETB: state_d = ST_EXEC;
      ST_EXEC: state_d = (dec_q.kind == K_CMP) ? ST_DONE : ST_WRC;
      ST_WRC:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done        = 1'b0;
    err         = 1'b0;
    datapath_in = '0;
    vsel        = 1'b0;
    writenum    = '0;
    readnum     = '0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = SH_NONE;
    ALUop       = ALU_ADD;
    case (state_q)
      ST_WIMM: begin
        vsel        = 1'b1;
        writenum    = dec_q.rn;
        write       = 1'b1;
        datapath_in = dec_q.imm;
      end
      ST_GETA: begin
        readnum = dec_q.rn;
        loada   = 1'b1;
      end
      ST_GETB: begin
        readnum = dec_q.rm;
        loadb   = 1'b1;
      end
      ST_EXEC: begin
        shift = dec_q.sh;
        // MOV-reg shares op=00 with ADD; zeroing A turns the add into a pass-through
        ALUop = (dec_q.kind == K_MOVR) ? ALU_ADD : dec_q.op;
        asel  = (dec_q.kind == K_MOVR) || (dec_q.kind == K_MVN);
        loadc = (dec_q.kind != K_CMP);
        loads = (dec_q.kind != K_MOVR);
      end
      ST_WRC: begin
        writenum = dec_q.rd;
        write    = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        in_valid;
  logic        in_ready, done, err, vsel, write;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] datapath_in;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;

  always #5 clk = ~clk;

  datapath_ctrl #(.DATA_W(16), .SEXT(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .done(done), .err(err), .datapath_in(datapath_in),
    .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- behavioural 16-bit datapath driven by the controller ----
  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [15:0] ra = '0, rb = '0, rc = '0;
  logic        z = 1'b0;
  logic [15:0] sh_out, ain, bin, alu_out;

  always_comb begin
    case (shift)
      2'b01:   sh_out = {rb[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, rb[15:1]};
      2'b11:   sh_out = {rb[15], rb[15:1]};
      default: sh_out = rb;
    endcase
    ain = asel ? 16'h0000 : ra;
    bin = bsel ? datapath_in : sh_out;
    case (ALUop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : rc;
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu_out;
    if (loads) z  <= (alu_out == 16'h0000);
  end

  // ---- scoreboard: expected completion cycle and kind ----
  typedef struct { int cyc; bit is_err; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected cyc=%0d done=%b err=%b", cyc, done, err);
      end else begin
        e = sb.pop_front();
        if ({done, err} !== {!e.is_err, e.is_err} || cyc != e.cyc) begin
          failures++;
          $display("FAIL sb_completion got cyc=%0d done=%b err=%b exp cyc=%0d err=%b",
                   cyc, done, err, e.cyc, e.is_err);
        end
      end
    end
  end

  // Present one word; lat<0 means no completion is expected.
  task automatic issue(input logic [15:0] w, input int lat, input bit is_err, output int acc);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1 instr=%h", in_ready, w);
    end
    instr    = w;
    in_valid = 1'b1;
    acc      = cyc;
    if (lat >= 0) sb.push_back('{acc + lat, is_err});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = ~w;   // must be ignored after acceptance
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({write, loada, loadb, loadc, loads, done, err, vsel, asel, bsel,
         shift, ALUop, writenum, readnum, datapath_in} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {write, loada, loadb, loadc, loads,
               done, err, vsel, asel, bsel, shift, ALUop, writenum, readnum, datapath_in});
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
  endtask

  task automatic test_load_add();
    int a;
    issue(16'hD102, 2, 1'b0, a);
    issue(16'hD007, 2, 1'b0, a);
    issue(16'hA148, 5, 1'b0, a);
    drain();
    checks++;
    if (rf[1] !== 16'h0002) begin failures++; $display("FAIL add_r1 got=%h exp=0002", rf[1]); end
    checks++;
    if (rf[0] !== 16'h0007) begin failures++; $display("FAIL add_r0 got=%h exp=0007", rf[0]); end
    checks++;
    if (rc !== 16'h0010 || rf[2] !== 16'h0010) begin
      failures++; $display("FAIL add_result got c=%h r2=%h exp=0010", rc, rf[2]);
    end
    checks++;
    if (z !== 1'b0) begin failures++; $display("FAIL add_z got=%b exp=0", z); end
  endtask

  task automatic test_compare();
    int a, nwr = 0, nlds = 0;
    bit lds_exec = 0;
    issue(16'hA901, 4, 1'b0, a);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      if (write) nwr++;
      if (loads) begin
        nlds++;
        if (cyc == a + 3) lds_exec = 1;
      end
    end
    drain();
    checks++;
    if (nwr != 0) begin failures++; $display("FAIL cmp_write got=%0d exp=0", nwr); end
    checks++;
    if (nlds != 1 || !lds_exec) begin
      failures++; $display("FAIL cmp_loads got=%0d in_exec=%b exp=1 in_exec=1", nlds, lds_exec);
    end
    checks++;
    if (z !== 1'b1) begin failures++; $display("FAIL cmp_z got=%b exp=1", z); end
  endtask

  task automatic test_complement();
    int a;
    issue(16'hB860, 4, 1'b0, a);
    @(negedge clk);
    @(negedge clk);   // cycle a+2: EXEC
    checks++;
    if ({asel, ALUop, loadc, loads} !== 5'b1_11_1_1) begin
      failures++;
      $display("FAIL mvn_exec got asel=%b aluop=%b loadc=%b loads=%b exp 1 11 1 1",
               asel, ALUop, loadc, loads);
    end
    drain();
    checks++;
    if (rf[3] !== 16'hFFF8) begin failures++; $display("FAIL mvn_r3 got=%h exp=fff8", rf[3]); end
  endtask

  task automatic test_illegal(input logic [15:0] w);
    int a;
    issue(w, 1, 1'b1, a);
    @(negedge clk);   // cycle a+1: ERR
    checks++;
    if ({write, loada, loadb, loadc, loads, done, vsel, in_ready} !== 8'd0 || err !== 1'b1) begin
      failures++;
      $display("FAIL ill_strobes instr=%h err=%b strobes=%b", w, err,
               {write, loada, loadb, loadc, loads, done, vsel, in_ready});
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    drain();
  endtask

  task automatic test_sext_movreg();
    int a;
    issue(16'hD4FF, 2, 1'b0, a);   // MOV R4,#-1
    issue(16'hC0B0, 4, 1'b0, a);   // MOV R5,R0,LSR#1
    drain();
    checks++;
    if (rf[4] !== 16'hFFFF) begin failures++; $display("FAIL sext_r4 got=%h exp=ffff", rf[4]); end
    checks++;
    if (rf[5] !== 16'h0003) begin failures++; $display("FAIL movr_r5 got=%h exp=0003", rf[5]); end
  endtask

  task automatic test_back_to_back();
    int a;
    @(negedge clk);
    instr = 16'hD6AA; in_valid = 1'b1; a = cyc;
    sb.push_back('{a + 2, 1'b0});
    sb.push_back('{a + 5, 1'b0});
    @(posedge clk);
    #1 instr = 16'hD705;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cyc != a + 3) begin
      failures++; $display("FAIL b2b_ready got=%b cyc=%0d exp=1 cyc=%0d", in_ready, cyc, a + 3);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    checks++;
    if (rf[6] !== 16'hFFAA || rf[7] !== 16'h0005) begin
      failures++; $display("FAIL b2b_regs got r6=%h r7=%h exp ffaa 0005", rf[6], rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    int a, ndone = 0;
    issue(16'hA1A0, -1, 1'b0, a);  // ADD R5,R1,R0
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                // cycle a+3: EXEC
    checks++;
    if (loadc !== 1'b1) begin failures++; $display("FAIL rmid_exec got loadc=%b exp=1", loadc); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || write !== 1'b0) begin
      failures++; $display("FAIL rmid_idle got ready=%b write=%b exp 1 0", in_ready, write);
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", ndone); end
    checks++;
    if (rf[5] !== 16'h0003) begin failures++; $display("FAIL rmid_r5 got=%h exp=0003", rf[5]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_add();
    test_compare();
    test_complement();
    test_illegal(16'hE000);
    test_illegal(16'hC800);
    test_sext_movreg();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
